// File: rtl/mem_stage_if.sv
// Signal bundle between mem_stage, the execute stage, the data bus and write-back.
// master: the memory stage itself; slave: the surrounding pipeline and memory.
interface mem_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_size;
    logic        ex_load_unsigned;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        wb_valid;
    logic [31:0] wb_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        exc_addr_err;
    logic        exc_bus_err;
    logic [31:0] exc_badvaddr;

    modport master (
        input  ex_valid, ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write, ex_size,
               ex_load_unsigned, ex_rd, ex_reg_write, bus_ack, bus_rdata,
        output ex_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
               wb_valid, wb_result, wb_rd, wb_reg_write, exc_addr_err, exc_bus_err, exc_badvaddr
    );

    modport slave (
        output ex_valid, ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write, ex_size,
               ex_load_unsigned, ex_rd, ex_reg_write, bus_ack, bus_rdata,
        input  ex_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
               wb_valid, wb_result, wb_rd, wb_reg_write, exc_addr_err, exc_bus_err, exc_badvaddr
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: ALU pass-through, aligned loads/stores over a single-outstanding
// req/ack bus with timeout, and one registered write-back record per instruction.
module mem_stage #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.master io_ms
);
    localparam int unsigned CntW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;

    typedef enum logic {StIdle, StBus} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [CntW-1:0] r_cnt;

    logic        r_we;
    logic        r_unsigned;
    logic        r_reg_write;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [4:0]  r_rd;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;

    logic        r_wb_valid;
    logic [31:0] r_wb_result;
    logic [4:0]  r_wb_rd;
    logic        r_wb_reg_write;
    logic        r_exc_addr_err;
    logic        r_exc_bus_err;
    logic [31:0] r_exc_badvaddr;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_is_store;
    logic        w_misalign;
    logic        w_start_bus;
    logic        w_tmo_hit;
    logic        w_ack;
    logic        w_timeout;
    logic [3:0]  w_be_in;
    logic [31:0] w_wdata_in;
    logic [31:0] w_rdata_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;

    assign w_accept    = io_ms.ex_valid && (r_state == StIdle);
    assign w_is_mem    = io_ms.ex_mem_read || io_ms.ex_mem_write;
    // read+write together is treated as a load
    assign w_is_store  = io_ms.ex_mem_write && !io_ms.ex_mem_read;
    assign w_start_bus = w_accept && w_is_mem && !w_misalign;
    assign w_tmo_hit   = (BUS_TIMEOUT != 0) && (r_cnt == CntW'(BUS_TIMEOUT - 1));
    assign w_ack       = (r_state == StBus) && io_ms.bus_ack;
    // an ack in the final allowed cycle wins over the timeout
    assign w_timeout   = (r_state == StBus) && !io_ms.bus_ack && w_tmo_hit;

    always_comb begin
        w_misalign = 1'b0;
        w_be_in    = 4'b1111;
        w_wdata_in = io_ms.ex_store_data;
        unique case (io_ms.ex_size)
            2'b00: begin
                w_be_in    = 4'b0001 << io_ms.ex_alu_result[1:0];
                w_wdata_in = {4{io_ms.ex_store_data[7:0]}};
            end
            2'b01: begin
                w_misalign = io_ms.ex_alu_result[0];
                w_be_in    = io_ms.ex_alu_result[1] ? 4'b1100 : 4'b0011;
                w_wdata_in = {2{io_ms.ex_store_data[15:0]}};
            end
            default: w_misalign = |io_ms.ex_alu_result[1:0];
        endcase
    end

    assign w_rdata_shift = io_ms.bus_rdata >> {r_addr[1:0], 3'b000};
    assign w_byte        = w_rdata_shift[7:0];
    assign w_half        = r_addr[1] ? io_ms.bus_rdata[31:16] : io_ms.bus_rdata[15:0];

    always_comb begin
        unique case (r_size)
            2'b00:   w_load_val = {{24{!r_unsigned && w_byte[7]}}, w_byte};
            2'b01:   w_load_val = {{16{!r_unsigned && w_half[15]}}, w_half};
            default: w_load_val = io_ms.bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_start_bus) w_state_next = StBus;
            StBus:   if (io_ms.bus_ack || w_tmo_hit) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        io_ms.ex_ready = (r_state == StIdle);
        io_ms.bus_req  = (r_state == StBus);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_start_bus) begin
            r_cnt <= '0;
        end else if ((r_state == StBus) && !io_ms.bus_ack) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we           <= 1'b0;
            r_unsigned     <= 1'b0;
            r_reg_write    <= 1'b0;
            r_size         <= 2'b00;
            r_addr         <= '0;
            r_rd           <= '0;
            r_be           <= '0;
            r_wdata        <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_result    <= '0;
            r_wb_rd        <= '0;
            r_wb_reg_write <= 1'b0;
            r_exc_addr_err <= 1'b0;
            r_exc_bus_err  <= 1'b0;
            r_exc_badvaddr <= '0;
        end else begin
            // write-back record is a single-cycle pulse; idle cycles present all zeros
            r_wb_valid     <= 1'b0;
            r_wb_result    <= '0;
            r_wb_rd        <= '0;
            r_wb_reg_write <= 1'b0;
            r_exc_addr_err <= 1'b0;
            r_exc_bus_err  <= 1'b0;
            r_exc_badvaddr <= '0;
            if (w_accept && !w_is_mem) begin
                r_wb_valid     <= 1'b1;
                r_wb_result    <= io_ms.ex_alu_result;
                r_wb_rd        <= io_ms.ex_rd;
                r_wb_reg_write <= io_ms.ex_reg_write;
            end else if (w_accept && w_misalign) begin
                r_wb_valid     <= 1'b1;
                r_wb_rd        <= io_ms.ex_rd;
                r_exc_addr_err <= 1'b1;
                r_exc_badvaddr <= io_ms.ex_alu_result;
            end else if (w_accept) begin
                r_we        <= w_is_store;
                r_unsigned  <= io_ms.ex_load_unsigned;
                r_reg_write <= io_ms.ex_reg_write;
                r_size      <= io_ms.ex_size;
                r_addr      <= io_ms.ex_alu_result;
                r_rd        <= io_ms.ex_rd;
                r_be        <= w_be_in;
                r_wdata     <= w_wdata_in;
            end else if (w_ack) begin
                r_wb_valid     <= 1'b1;
                r_wb_rd        <= r_rd;
                r_wb_result    <= r_we ? 32'd0 : w_load_val;
                r_wb_reg_write <= !r_we && r_reg_write;
            end else if (w_timeout) begin
                r_wb_valid     <= 1'b1;
                r_wb_rd        <= r_rd;
                r_exc_bus_err  <= 1'b1;
                r_exc_badvaddr <= r_addr;
            end
        end
    end

    assign io_ms.bus_we       = r_we;
    assign io_ms.bus_addr     = {r_addr[31:2], 2'b00};
    assign io_ms.bus_be       = r_be;
    assign io_ms.bus_wdata    = r_wdata;
    assign io_ms.wb_valid     = r_wb_valid;
    assign io_ms.wb_result    = r_wb_result;
    assign io_ms.wb_rd        = r_wb_rd;
    assign io_ms.wb_reg_write = r_wb_reg_write;
    assign io_ms.exc_addr_err = r_exc_addr_err;
    assign io_ms.exc_bus_err  = r_exc_bus_err;
    assign io_ms.exc_badvaddr = r_exc_badvaddr;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a per-cycle scoreboard of write-back records and bus state,
// plus literal expectations for the listed scenarios.
module tb_mem_stage;
    localparam int unsigned TMO = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_stage_if ms_if ();

    mem_stage #(.BUS_TIMEOUT(TMO)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_ms (ms_if)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] data;
        logic        rd_en;
        logic        wr_en;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  rd;
        logic        rw;
    } op_t;

    typedef struct {
        int          cyc;
        logic [72:0] vec;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    logic        m_busy = 1'b0;
    logic [68:0] m_bus = '0;
    logic        snap_we, snap_ready;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_be;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic op_t mk(input logic [31:0] alu, input logic [31:0] data,
                               input logic rd_en, input logic wr_en, input logic [1:0] size,
                               input logic uns, input logic [4:0] rd, input logic rw);
        op_t o;
        o.alu = alu; o.data = data; o.rd_en = rd_en; o.wr_en = wr_en;
        o.size = size; o.uns = uns; o.rd = rd; o.rw = rw;
        return o;
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit misaligned(input op_t o);
        int off = int'(o.alu[1:0]);
        return (o.rd_en || o.wr_en) && ((off % nbytes(o.size)) != 0);
    endfunction

    function automatic logic [3:0] exp_be(input op_t o);
        int off = int'(o.alu[1:0]);
        return 4'(((32'd1 << nbytes(o.size)) - 32'd1) << off);
    endfunction

    function automatic logic [31:0] exp_wdata(input op_t o);
        logic [31:0] w;
        int nb = nbytes(o.size);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = o.data[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] load_val(input op_t o, input logic [31:0] rdata);
        int nb = nbytes(o.size);
        int off = int'(o.alu[1:0]);
        logic [31:0] mask, v;
        if (nb == 4) return rdata;
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v = (rdata >> (8 * off)) & mask;
        if (!o.uns && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [72:0] wbv(input logic [31:0] res, input logic [4:0] rd,
                                        input logic rw, input logic aerr, input logic berr,
                                        input logic [31:0] bad);
        return {1'b1, res, rd, rw, aerr, berr, bad};
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk73(input string name, input logic [72:0] act, input logic [72:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [72:0] exp_wb, act_wb, exp_bus, act_bus;
        logic [31:0] wd;
        exp_wb = '0;
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            exp_wb = exp_q[0].vec;
            void'(exp_q.pop_front());
        end
        act_wb = {ms_if.wb_valid, ms_if.wb_result, ms_if.wb_rd, ms_if.wb_reg_write,
                  ms_if.exc_addr_err, ms_if.exc_bus_err, ms_if.exc_badvaddr};
        chk73("wb_record", act_wb, exp_wb);
        // write data only meaningful for stores
        wd = ms_if.bus_we ? ms_if.bus_wdata : 32'd0;
        exp_bus = {2'b00, !m_busy, m_busy, m_busy ? m_bus : 69'd0};
        act_bus = {2'b00, ms_if.ex_ready, ms_if.bus_req,
                   m_busy ? {ms_if.bus_we, ms_if.bus_addr, ms_if.bus_be, wd} : 69'd0};
        chk73("bus_state", act_bus, exp_bus);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_t o);
        ms_if.ex_valid         = 1'b1;
        ms_if.ex_alu_result    = o.alu;
        ms_if.ex_store_data    = o.data;
        ms_if.ex_mem_read      = o.rd_en;
        ms_if.ex_mem_write     = o.wr_en;
        ms_if.ex_size          = o.size;
        ms_if.ex_load_unsigned = o.uns;
        ms_if.ex_rd            = o.rd;
        ms_if.ex_reg_write     = o.rw;
    endtask

    task automatic quiet();
        drive(mk(32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0));
        ms_if.ex_valid = 1'b0;
    endtask

    task automatic set_bus_model(input op_t o);
        logic st;
        st = o.wr_en && !o.rd_en;
        m_busy = 1'b1;
        m_bus = {st, o.alu[31:2], 2'b00, exp_be(o), st ? exp_wdata(o) : 32'd0};
    endtask

    // Non-memory or misaligned op: record expected one cycle after acceptance.
    task automatic issue_imm(input op_t o);
        drive(o);
        if (misaligned(o)) exp_q.push_back('{cyc + 1, wbv(32'd0, o.rd, 1'b0, 1'b1, 1'b0, o.alu)});
        else exp_q.push_back('{cyc + 1, wbv(o.alu, o.rd, o.rw, 1'b0, 1'b0, 32'd0)});
        tick();
    endtask

    // Aligned memory op; ack in the wait_n-th bus cycle, or no ack at all (timeout).
    task automatic mem_op(input op_t o, input int wait_n, input logic [31:0] rdata,
                          input bit acked);
        drive(o);
        tick();
        quiet();
        set_bus_model(o);
        snap_we = ms_if.bus_we; snap_addr = ms_if.bus_addr; snap_be = ms_if.bus_be;
        snap_wdata = ms_if.bus_wdata; snap_ready = ms_if.ex_ready;
        if (acked) begin
            repeat (wait_n - 1) tick();
            ms_if.bus_ack = 1'b1;
            ms_if.bus_rdata = rdata;
            if (o.rd_en)
                exp_q.push_back('{cyc + 1, wbv(load_val(o, rdata), o.rd, o.rw, 1'b0, 1'b0, 32'd0)});
            else
                exp_q.push_back('{cyc + 1, wbv(32'd0, o.rd, 1'b0, 1'b0, 1'b0, 32'd0)});
            tick();
            ms_if.bus_ack = 1'b0;
            ms_if.bus_rdata = 32'd0;
        end else begin
            repeat (int'(TMO) - 1) tick();
            exp_q.push_back('{cyc + 1, wbv(32'd0, o.rd, 1'b0, 1'b0, 1'b1, o.alu)});
            tick();
        end
        m_busy = 1'b0;
    endtask

    initial begin
        quiet();
        ms_if.bus_ack = 1'b0;
        ms_if.bus_rdata = 32'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk32("rst_bus_req", 32'(ms_if.bus_req), 32'd0);
        chk32("rst_ex_ready", 32'(ms_if.ex_ready), 32'd1);
        chk32("rst_wb_valid", 32'(ms_if.wb_valid), 32'd0);
        chk32("rst_bus_addr", ms_if.bus_addr, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // back-to-back pass-through
        issue_imm(mk(32'h11, 32'd0, 1'b0, 1'b0, 2'd2, 1'b0, 5'd3, 1'b1));
        chk32("nm1_result", ms_if.wb_result, 32'h11);
        chk32("nm1_ready", 32'(ms_if.ex_ready), 32'd1);
        issue_imm(mk(32'h22, 32'd0, 1'b0, 1'b0, 2'd2, 1'b0, 5'd4, 1'b1));
        chk32("nm2_result", ms_if.wb_result, 32'h22);
        chk32("nm2_rd", 32'(ms_if.wb_rd), 32'd4);
        quiet();
        tick();

        // lb / lbu from 0x1003
        mem_op(mk(32'h1003, 32'd0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd5, 1'b1), 3, 32'h80FF0000, 1'b1);
        chk32("lb_be", 32'(snap_be), 32'h8);
        chk32("lb_addr", snap_addr, 32'h1000);
        chk32("lb_ready_busy", 32'(snap_ready), 32'd0);
        chk32("lb_result", ms_if.wb_result, 32'hFFFFFF80);
        mem_op(mk(32'h1003, 32'd0, 1'b1, 1'b0, 2'd0, 1'b1, 5'd6, 1'b1), 3, 32'h80FF0000, 1'b1);
        chk32("lbu_result", ms_if.wb_result, 32'h00000080);

        // sh 0x1234ABCD to 0x2002
        mem_op(mk(32'h2002, 32'h1234ABCD, 1'b0, 1'b1, 2'd1, 1'b0, 5'd7, 1'b1), 1, 32'd0, 1'b1);
        chk32("sh_we", 32'(snap_we), 32'd1);
        chk32("sh_be", 32'(snap_be), 32'hC);
        chk32("sh_wdata", snap_wdata, 32'hABCDABCD);
        chk32("sh_addr", snap_addr, 32'h2000);
        chk32("sh_regwrite", 32'(ms_if.wb_reg_write), 32'd0);

        // misaligned lw
        issue_imm(mk(32'h3001, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd8, 1'b1));
        chk32("lw_mis_aerr", 32'(ms_if.exc_addr_err), 32'd1);
        chk32("lw_mis_bad", ms_if.exc_badvaddr, 32'h3001);
        chk32("lw_mis_regwrite", 32'(ms_if.wb_reg_write), 32'd0);
        chk32("lw_mis_req", 32'(ms_if.bus_req), 32'd0);
        quiet();
        tick();

        // more lanes: lh, lhu, sb, size 11, read+write as load, misaligned half
        mem_op(mk(32'h4002, 32'd0, 1'b1, 1'b0, 2'd1, 1'b0, 5'd9, 1'b1), 2, 32'h80017FFF, 1'b1);
        chk32("lh_result", ms_if.wb_result, 32'hFFFF8001);
        mem_op(mk(32'h4000, 32'd0, 1'b1, 1'b0, 2'd1, 1'b1, 5'd10, 1'b1), 1, 32'h8001FFFF, 1'b1);
        chk32("lhu_result", ms_if.wb_result, 32'h0000FFFF);
        mem_op(mk(32'h6001, 32'h000000AB, 1'b0, 1'b1, 2'd0, 1'b0, 5'd11, 1'b0), 2, 32'd0, 1'b1);
        chk32("sb_be", 32'(snap_be), 32'h2);
        chk32("sb_wdata", snap_wdata, 32'hABABABAB);
        mem_op(mk(32'h5004, 32'd0, 1'b1, 1'b0, 2'd3, 1'b0, 5'd12, 1'b1), 1, 32'h12345678, 1'b1);
        mem_op(mk(32'h7000, 32'h55, 1'b1, 1'b1, 2'd2, 1'b0, 5'd13, 1'b1), 1, 32'hA5A5A5A5, 1'b1);
        chk32("rw_as_load_we", 32'(snap_we), 32'd0);
        issue_imm(mk(32'h4003, 32'd0, 1'b1, 1'b0, 2'd1, 1'b0, 5'd14, 1'b1));
        quiet();

        // bus_ack outside BUS is ignored
        ms_if.bus_ack = 1'b1;
        tick();
        tick();
        ms_if.bus_ack = 1'b0;

        // timeout, then ack in the final cycle
        mem_op(mk(32'h8000, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd15, 1'b1), 0, 32'd0, 1'b0);
        chk32("tmo_berr", 32'(ms_if.exc_bus_err), 32'd1);
        chk32("tmo_bad", ms_if.exc_badvaddr, 32'h8000);
        chk32("tmo_req", 32'(ms_if.bus_req), 32'd0);
        mem_op(mk(32'h8004, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd16, 1'b1), int'(TMO), 32'hCAFEF00D,
               1'b1);
        chk32("ack_last_result", ms_if.wb_result, 32'hCAFEF00D);
        chk32("ack_last_berr", 32'(ms_if.exc_bus_err), 32'd0);

        // reset while a transaction is in flight
        drive(mk(32'h9000, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd17, 1'b1));
        tick();
        quiet();
        set_bus_model(mk(32'h9000, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0, 5'd17, 1'b1));
        tick();
        #2;
        rst_n = 1'b0;
        m_busy = 1'b0;
        #1;
        chk32("rstmid_req", 32'(ms_if.bus_req), 32'd0);
        chk32("rstmid_ready", 32'(ms_if.ex_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        issue_imm(mk(32'h55, 32'd0, 1'b0, 1'b0, 2'd2, 1'b0, 5'd18, 1'b1));
        chk32("post_rst_result", ms_if.wb_result, 32'h55);
        quiet();
        repeat (3) tick();
        chk32("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
